imem_port_arbiter: RTL
======================

// Module: imem_port_arbiter
// PURPOSE
// - Shares the single-port instruction memory between the fetch stage (F) and a loader/debug port (L).
// - Fetch has priority; loader starvation is bounded by an aging counter; the loader may lock the port for a short burst.
// - Emits fetch_hold to the fetch stage whenever F requests but is not granted; fetch treats it as a stall.
// - Sits between pipeline fetch/prediction and the im block.
// PARAMETERS
// STARVE_LIMIT  4  consecutive F-granted cycles with L pending before L is forced in; legal range 1..15
// MAX_BURST     8  maximum consecutive locked L grants; legal range 1..15
// PORTS
// clk        in   1   clock, rising edge
// rst        in   1   asynchronous active-low reset; 0 = reset asserted
// f_req      in   1   fetch read request
// f_addr     in   32  fetch read address
// f_gnt      out  1   fetch granted this cycle (comb)
// f_rvalid   out  1   fetch read data valid (one cycle after f_gnt)
// fetch_hold out  1   f_req && !f_gnt (comb)
// l_req      in   1   loader request
// l_we       in   1   loader write (1) / read (0)
// l_lock     in   1   keep port after this grant (burst)
// l_addr     in   32  loader address
// l_wdata    in   32  loader write data
// l_gnt      out  1   loader granted this cycle (comb)
// l_rvalid   out  1   loader read data valid (one cycle after granted read)
// rdata      out  32  = m_rdata, shared by both requesters
// m_en       out  1   memory enable
// m_we       out  1   memory write enable
// m_addr     out  32  memory address, muxed from grantee
// m_wdata    out  32  = l_wdata
// m_rdata    in   32  memory read data, 1-cycle latency
// perf_hold  out  32  fetch_hold cycle count (see CONFIGURATION)
// perf_force out  16  forced loader grant count (see CONFIGURATION)
// BEHAVIOUR
// - States: ARB, L_BURST; reset -> ARB, starve_cnt=0, burst_cnt=0, resp owner=none.
// - Reset values: f_rvalid=0, l_rvalid=0; perf counters 0; comb outputs follow inputs.
// - ARB grant:
//   - F only -> F.
//   - L only -> L.
//   - both -> F unless starve_cnt==STARVE_LIMIT, then L (forced).
//   - none -> m_en=0.
// - starve_cnt:
//   - +1 on each cycle F granted while l_req=1, saturating at STARVE_LIMIT.
//   - Cleared on any L grant or when l_req=0.
// - L grant with l_lock=1 in ARB -> L_BURST, burst_cnt=1.
// - L_BURST:
//   - L granted each cycle l_req=1; burst_cnt+1 per grant.
//   - F held (fetch_hold=1 if f_req).
//   - Exit to ARB when l_req=0, l_lock=0, or burst_cnt==MAX_BURST (that cycle's grant is the last L grant).
// - m_we = l_gnt && l_we; m_en = f_gnt || l_gnt; f_gnt and l_gnt never both 1.
// - Response: owner register captures {F, L-read, none} at grant; next cycle raises f_rvalid or l_rvalid for one cycle.
//   - L writes produce no rvalid.
//   - Back-to-back grants to alternating owners must route each response correctly.
// - Requests are level-sensitive; a requester not granted must keep its request and address stable; no queuing inside.
// - Async reset mid-burst or with a response in flight: return to ARB immediately; the pending rvalid is dropped.
// - Parameter values outside legal range: elaboration error via a generate-time check.
// CONFIGURATION
// IMEM_ARB_PERF_EN defined:
// - perf_hold increments each cycle fetch_hold=1, saturating at 32'hFFFFFFFF.
// - perf_force increments on each forced L grant, saturating at 16'hFFFF.
// - Both cleared only by reset.
// IMEM_ARB_PERF_EN undefined:
// - No counter flops; perf_hold=0 and perf_force=0 constantly.
// - Arbitration is identical either way.
// TESTING
// - f_req=1 only, f_addr=0x100,0x104,0x108 -> f_gnt every cycle, f_rvalid 1 cycle later, m_addr sequence matches, fetch_hold=0.
// - f_req=1 and l_req=1 (read 0x40) continuously, STARVE_LIMIT=4 -> 4 F grants, 1 L grant (perf_force=1), then 4 F again; l_rvalid on cycle after the L grant.
// - l_req=1, l_lock=1, l_we=1 held 12 cycles with f_req=1, MAX_BURST=8 -> exactly 8 L writes, fetch_hold=1 for those 8 cycles, then F granted; no l_rvalid.
// - Alternate grants F,L-read,F -> f_rvalid,l_rvalid,f_rvalid in next cycles with rdata matching each addressed word.
// - rst driven 0 mid-burst (burst_cnt=3) with read in flight -> next cycle state ARB, no rvalid, perf counters 0, F granted after rst=1.
// - IMEM_ARB_PERF_EN off -> perf_hold, perf_force stay 0 through all above scenarios.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the single-port instruction memory between
// fetch (F, priority) and loader/debug (L, aged + lockable bursts).
// Ports: clk, rst (async, active-low); F side f_req/f_addr -> f_gnt,
// f_rvalid, fetch_hold; L side l_req/l_we/l_lock/l_addr/l_wdata ->
// l_gnt, l_rvalid; shared rdata; memory side m_en/m_we/m_addr/m_wdata,
// m_rdata (1-cycle latency); perf_hold/perf_force counters.
// Optional: define IMEM_ARB_PERF_EN to build the perf counters;
// otherwise both perf outputs are tied to zero.
module imem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic        fetch_hold,
  input  logic        l_req,
  input  logic        l_we,
  input  logic        l_lock,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic        l_rvalid,
  output logic [31:0] rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic [31:0] perf_hold,
  output logic [15:0] perf_force
);

  generate
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
      $error("imem_port_arbiter: STARVE_LIMIT must be 1..15");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
      $error("imem_port_arbiter: MAX_BURST must be 1..15");
    end
  endgenerate

  localparam logic [3:0] SL = 4'(STARVE_LIMIT);
  localparam logic [3:0] MB = 4'(MAX_BURST);

  typedef enum logic {
    ARB,
    L_BURST
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_F,
    OWN_L
  } own_t;

  state_t     state_q, state_d;
  own_t       own_q, own_d;
  logic [3:0] starve_q, starve_d;
  logic [3:0] burst_q, burst_d;
  logic       forced;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB;
      own_q    <= OWN_NONE;
      starve_q <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    burst_d  = burst_q;
    f_gnt    = 1'b0;
    l_gnt    = 1'b0;
    forced   = 1'b0;
    unique case (state_q)
      ARB: begin
        forced = f_req && l_req && (starve_q == SL);
        l_gnt  = l_req && (!f_req || forced);
        f_gnt  = f_req && !l_gnt;
        // a one-grant burst limit means the lock never holds the port
        if (l_gnt && l_lock && (MB != 4'd1)) begin
          state_d = L_BURST;
          burst_d = 4'd1;
        end
      end
      L_BURST: begin
        l_gnt = l_req;
        if (l_req) burst_d = burst_q + 4'd1;
        // the grant that reaches MB is the last one of the burst
        if (!l_req || !l_lock || burst_d == MB) state_d = ARB;
      end
    endcase
    if (l_gnt || !l_req) starve_d = '0;
    else if (f_gnt && starve_q != SL) starve_d = starve_q + 4'd1;
  end

  always_comb begin
    own_d = OWN_NONE;
    if (f_gnt) own_d = OWN_F;
    else if (l_gnt && !l_we) own_d = OWN_L;
  end

  assign f_rvalid   = (own_q == OWN_F);
  assign l_rvalid   = (own_q == OWN_L);
  assign fetch_hold = f_req && !f_gnt;
  assign rdata      = m_rdata;
  assign m_en       = f_gnt || l_gnt;
  assign m_we       = l_gnt && l_we;
  assign m_addr     = l_gnt ? l_addr : f_addr;
  assign m_wdata    = l_wdata;

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] hold_q;
  logic [15:0] force_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q  <= '0;
      force_q <= '0;
    end else begin
      if (fetch_hold && hold_q != '1) hold_q <= hold_q + 32'd1;
      if (forced && force_q != '1) force_q <= force_q + 16'd1;
    end
  end

  assign perf_hold  = hold_q;
  assign perf_force = force_q;
`else
  assign perf_hold  = '0;
  assign perf_force = '0;
`endif

endmodule
